// File: rtl/multi_watch_pkg.sv
// multi_watch_pkg: BCD time types, digit limits and seven-segment table shared by the watch.
package multi_watch_pkg;
    typedef logic [3:0] bcd_t;
    typedef struct packed {
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } time_t;
    localparam bcd_t UNIT_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;
    // Entry n sits at bits [7n+6:7n], segments g..a.
    localparam logic [69:0] SEG_TBL = {7'h6F, 7'h7F, 7'h27, 7'h7D, 7'h6D,
                                       7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    function automatic logic [6:0] seg_enc(input bcd_t d);
        return (d <= UNIT_MAX) ? 7'(SEG_TBL >> (7 * int'(d))) : 7'h00;
    endfunction
    function automatic bcd_t clamp(input bcd_t d, input bcd_t mx);
        return (d > mx) ? mx : d;
    endfunction
endpackage

// File: rtl/multi_watch_if.sv
// multi_watch_if: control inputs, status pulses and Pmod display lines of the watch.
interface multi_watch_if;
    logic        run;
    logic        clr;
    logic        down;
    logic        load;
    logic [15:0] load_val;
    logic        tick;
    logic        wrap;
    logic        done;
    logic [7:0]  jc;
    logic [7:0]  jd;
    modport master (output run, clr, down, load, load_val, input tick, wrap, done, jc, jd);
    modport slave  (input run, clr, down, load, load_val, output tick, wrap, done, jc, jd);
endinterface

// File: rtl/ssd_pmod_drv.sv
// ssd_pmod_drv: multiplexes the BCD time onto two Pmod SSD modules with registered outputs.
module ssd_pmod_drv
    import multi_watch_pkg::*;
#(
    parameter int SCAN_DIV  = 65536,
    parameter int CC_ACTIVE = 1
) (
    input  logic       sysclk,
    input  logic       rst,
    input  time_t      i_time,
    output logic [7:0] o_jc,
    output logic [7:0] o_jd
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic CC = (CC_ACTIVE != 0);
    logic [SW-1:0] r_scan;
    logic          r_sel;
    logic          w_scan_wrap;
    assign w_scan_wrap = (r_scan == SW'(SCAN_DIV - 1));
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_scan <= '0;
            r_sel  <= 1'b0;
            o_jc   <= {~CC, 7'h3F};
            o_jd   <= {~CC, 7'h3F};
        end else begin
            r_scan <= w_scan_wrap ? '0 : r_scan + 1'b1;
            if (w_scan_wrap) r_sel <= ~r_sel;
            o_jc   <= {r_sel ~^ CC, seg_enc(r_sel ? i_time.s1 : i_time.s0)};
            o_jd   <= {r_sel ~^ CC, seg_enc(r_sel ? i_time.m1 : i_time.m0)};
        end
    end
endmodule

// File: rtl/multi_watch.sv
// multi_watch: mm:ss up/down stopwatch with one-second prescaler and Pmod SSD display.
module multi_watch
    import multi_watch_pkg::*;
#(
    parameter int CLK_HZ    = 125000000,
    parameter int SCAN_DIV  = 65536,
    parameter int CC_ACTIVE = 1
) (
    input  logic   sysclk,
    input  logic   rst,
    multi_watch_if.slave bus
);
    localparam int PW = $clog2(CLK_HZ);
    logic [PW-1:0] r_pre;
    time_t         r_time;
    logic          r_tick;
    logic          r_wrap;
    logic          r_done;
    time_t         w_up;
    time_t         w_dn;
    time_t         w_ld;
    time_t         w_lv;
    logic          w_step;
    logic          w_zero;
    logic          w_max;
    logic          w_hold;
    logic          w_c0, w_c1, w_c2;
    logic          w_b0, w_b1, w_b2;
    assign w_lv   = bus.load_val;
    assign w_step = bus.run && (r_pre == PW'(CLK_HZ - 1));
    assign w_zero = (r_time == '0);
    assign w_max  = (r_time == 16'h5959);
    assign w_hold = bus.down && (r_done || w_zero);
    always_comb begin
        w_c0    = (r_time.s0 == UNIT_MAX);
        w_c1    = w_c0 && (r_time.s1 == TENS_MAX);
        w_c2    = w_c1 && (r_time.m0 == UNIT_MAX);
        w_up.s0 = w_c0 ? 4'd0 : r_time.s0 + 4'd1;
        w_up.s1 = w_c0 ? (w_c1 ? 4'd0 : r_time.s1 + 4'd1) : r_time.s1;
        w_up.m0 = w_c1 ? (w_c2 ? 4'd0 : r_time.m0 + 4'd1) : r_time.m0;
        w_up.m1 = w_c2 ? ((r_time.m1 == TENS_MAX) ? 4'd0 : r_time.m1 + 4'd1) : r_time.m1;
        w_b0    = (r_time.s0 == 4'd0);
        w_b1    = w_b0 && (r_time.s1 == 4'd0);
        w_b2    = w_b1 && (r_time.m0 == 4'd0);
        w_dn.s0 = w_b0 ? UNIT_MAX : r_time.s0 - 4'd1;
        w_dn.s1 = w_b0 ? (w_b1 ? TENS_MAX : r_time.s1 - 4'd1) : r_time.s1;
        w_dn.m0 = w_b1 ? (w_b2 ? UNIT_MAX : r_time.m0 - 4'd1) : r_time.m0;
        w_dn.m1 = w_b2 ? r_time.m1 - 4'd1 : r_time.m1;
        w_ld.s0 = clamp(w_lv.s0, UNIT_MAX);
        w_ld.s1 = clamp(w_lv.s1, TENS_MAX);
        w_ld.m0 = clamp(w_lv.m0, UNIT_MAX);
        w_ld.m1 = clamp(w_lv.m1, TENS_MAX);
    end
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_time <= '0;
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.clr) begin
                r_time <= '0;
                r_pre  <= '0;
                r_done <= 1'b0;
            end else if (bus.load) begin
                r_time <= w_ld;
                r_pre  <= '0;
                r_done <= bus.down && (w_ld == '0);
            end else begin
                if (bus.run) r_pre <= w_step ? '0 : r_pre + 1'b1;
                if (!bus.down) r_done <= 1'b0;
                // A down-count parked at 00:00 swallows steps silently.
                if (w_step && w_hold) begin
                    r_done <= 1'b1;
                end else if (w_step) begin
                    r_tick <= 1'b1;
                    if (bus.down) begin
                        r_time <= w_dn;
                        r_done <= (w_dn == '0);
                    end else begin
                        r_time <= w_up;
                        r_wrap <= w_max;
                    end
                end
            end
        end
    end
    assign bus.tick = r_tick;
    assign bus.wrap = r_wrap;
    assign bus.done = r_done;
    ssd_pmod_drv #(
        .SCAN_DIV (SCAN_DIV),
        .CC_ACTIVE(CC_ACTIVE)
    ) u_drv (
        .sysclk(sysclk),
        .rst   (rst),
        .i_time(r_time),
        .o_jc  (bus.jc),
        .o_jd  (bus.jd)
    );
endmodule

// File: tb/tb_multi_watch.sv
// tb_multi_watch: directed checks of counting, clamping, done/wrap and display scan.
module tb_multi_watch;
    logic sysclk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_tick;
    int   n_wrap;
    int   m_cnt;
    logic m_sel;
    logic m_seld;
    multi_watch_if bus();
    multi_watch #(.CLK_HZ(4), .SCAN_DIV(2), .CC_ACTIVE(1)) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus)
    );
    always #5 sysclk = ~sysclk;
    // Expected digit-select phase, as seen on the registered outputs.
    always @(posedge sysclk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_sel  <= 1'b0;
            m_seld <= 1'b0;
        end else begin
            m_seld <= m_sel;
            if (m_cnt == 1) begin
                m_cnt <= 0;
                m_sel <= ~m_sel;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask
    task automatic do_load(input logic [15:0] v);
        bus.load_val = v;
        bus.load = 1'b1;
        cyc(1);
        bus.load = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.run = 1'b0;
        bus.clr = 1'b0;
        bus.down = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        cyc(2);
        check("rst_time", 32'(dut.r_time), 32'h0000);
        check("rst_jc", 32'(bus.jc), 32'h3F);
        check("rst_jd", 32'(bus.jd), 32'h3F);
        check("rst_flags", {bus.tick, bus.wrap, bus.done}, 3'b000);
        rst = 1'b0;
        bus.run = 1'b1;
        n_tick = 0;
        n_wrap = 0;
        for (int i = 0; i < 240; i++) begin
            cyc(1);
            n_tick += int'(bus.tick);
            n_wrap += int'(bus.wrap);
        end
        bus.run = 1'b0;
        check("up60_ticks", n_tick, 60);
        check("up60_wrap", n_wrap, 0);
        check("up60_time", 32'(dut.r_time), 32'h0100);
        do_load(16'h5958);
        bus.run = 1'b1;
        cyc(4);
        check("w1_time", 32'(dut.r_time), 32'h5959);
        check("w1_tw", {bus.tick, bus.wrap}, 2'b10);
        cyc(4);
        check("w2_time", 32'(dut.r_time), 32'h0000);
        check("w2_tw", {bus.tick, bus.wrap}, 2'b11);
        bus.run = 1'b0;
        bus.down = 1'b1;
        do_load(16'h0002);
        check("dn_done0", 32'(bus.done), 32'h0);
        bus.run = 1'b1;
        cyc(4);
        check("dn1_time", 32'(dut.r_time), 32'h0001);
        check("dn1_td", {bus.tick, bus.done}, 2'b10);
        cyc(4);
        check("dn2_time", 32'(dut.r_time), 32'h0000);
        check("dn2_td", {bus.tick, bus.done}, 2'b11);
        n_tick = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            n_tick += int'(bus.tick);
        end
        check("dnh_ticks", n_tick, 0);
        check("dnh_time", 32'(dut.r_time), 32'h0000);
        check("dnh_done", 32'(bus.done), 32'h1);
        bus.run = 1'b0;
        bus.down = 1'b0;
        cyc(1);
        check("dnh_clr", 32'(bus.done), 32'h0);
        do_load(16'h0010);
        bus.run = 1'b1;
        cyc(2);
        bus.down = 1'b1;
        cyc(2);
        check("mid_time", 32'(dut.r_time), 32'h0009);
        check("mid_tick", 32'(bus.tick), 32'h1);
        bus.run = 1'b0;
        bus.down = 1'b0;
        do_load(16'hFA7C);
        check("clamp", 32'(dut.r_time), 32'h5959);
        bus.clr = 1'b1;
        do_load(16'h1234);
        bus.clr = 1'b0;
        check("clr_load", 32'(dut.r_time), 32'h0000);
        bus.down = 1'b1;
        do_load(16'h0000);
        check("ld0_done", 32'(bus.done), 32'h1);
        bus.down = 1'b0;
        do_load(16'h1234);
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("scan_jc", 32'(bus.jc), m_seld ? 32'hCF : 32'h66);
            check("scan_jd", 32'(bus.jd), m_seld ? 32'h86 : 32'h5B);
        end
        do_load(16'h0745);
        bus.run = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.run = 1'b0;
        check("mrst_time", 32'(dut.r_time), 32'h0000);
        check("mrst_jc", 32'(bus.jc), 32'h3F);
        check("mrst_jd", 32'(bus.jd), 32'h3F);
        check("mrst_tick", 32'(bus.tick), 32'h0);
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
